// File: rtl/keypad_code_lock.sv
// Four-digit keypad code lock: synchronises the scanner strobe, collects BCD digits,
// checks them against a stored code and drives unlock/alarm with failure lockout.
module keypad_code_lock #(
   parameter logic [15:0] CODE_INIT    = 16'h1234,
   parameter logic [23:0] TIMEOUT      = 24'd4_000_000,
   parameter logic [23:0] UNLOCK_TIME  = 24'd8_000_000,
   parameter logic [23:0] LOCKOUT_TIME = 24'd16_000_000,
   parameter logic [1:0]  MAX_FAIL     = 2'd3
) (
   input  logic        fin,
   input  logic        rst,
   input  logic [3:0]  keycode,
   input  logic        key_pulse,
   output logic        unlock,
   output logic        alarm,
   output logic        fail_pulse,
   output logic        saved_pulse,
   output logic [15:0] entry,
   output logic [2:0]  digit_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENTRY,
      S_CHECK,
      S_OPEN,
      S_LOCKOUT
   } state_t;

   state_t      r_state;
   logic [2:0]  r_sync;
   logic [23:0] r_timer;
   logic [15:0] r_entry;
   logic [2:0]  r_digit_cnt;
   logic [15:0] r_code;
   logic [1:0]  r_fail_cnt;
   logic        r_unlock;
   logic        r_alarm;
   logic        r_fail_pulse;
   logic        r_saved_pulse;

   logic        w_key_evt;
   logic        w_is_digit;
   logic        w_is_clear;
   logic        w_is_enter;
   logic        w_expired;
   logic        w_full;
   logic        w_pass;
   logic [1:0]  w_fail_next;
   logic [15:0] w_shift;

   // r_sync[1:0] is the 2-FF synchroniser, r_sync[2] the delayed copy for edge detect
   always_ff @(posedge fin or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[1:0], key_pulse};
      end
   end

   assign w_key_evt   = r_sync[1] & ~r_sync[2];
   assign w_is_digit  = (keycode <= 4'd9);
   assign w_is_clear  = (keycode == 4'd10);
   assign w_is_enter  = (keycode == 4'd11);
   assign w_expired   = (r_timer == '0);
   assign w_full      = (r_digit_cnt == 3'd4);
   assign w_pass      = w_full && (r_entry == r_code);
   assign w_fail_next = r_fail_cnt + 2'd1;
   assign w_shift     = {r_entry[11:0], keycode};

   always_ff @(posedge fin or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_timer       <= '0;
         r_entry       <= '0;
         r_digit_cnt   <= '0;
         r_code        <= CODE_INIT;
         r_fail_cnt    <= '0;
         r_unlock      <= 1'b0;
         r_alarm       <= 1'b0;
         r_fail_pulse  <= 1'b0;
         r_saved_pulse <= 1'b0;
      end else begin
         r_fail_pulse  <= 1'b0;
         r_saved_pulse <= 1'b0;
         if (!w_expired) begin
            r_timer <= r_timer - 24'd1;
         end

         case (r_state)
            S_IDLE: begin
               if (w_key_evt && w_is_digit) begin
                  r_state     <= S_ENTRY;
                  r_entry     <= {12'h000, keycode};
                  r_digit_cnt <= 3'd1;
                  r_timer     <= TIMEOUT;
               end
            end

            S_ENTRY: begin
               if (w_expired) begin
                  r_state     <= S_IDLE;
                  r_entry     <= '0;
                  r_digit_cnt <= '0;
               end else if (w_key_evt) begin
                  if (w_is_digit) begin
                     r_timer <= TIMEOUT;
                     if (!w_full) begin
                        r_entry     <= w_shift;
                        r_digit_cnt <= r_digit_cnt + 3'd1;
                     end
                  end else if (w_is_clear) begin
                     r_state     <= S_IDLE;
                     r_entry     <= '0;
                     r_digit_cnt <= '0;
                  end else if (w_is_enter) begin
                     r_state <= S_CHECK;
                  end
               end
            end

            S_CHECK: begin
               r_entry     <= '0;
               r_digit_cnt <= '0;
               if (w_pass) begin
                  r_state    <= S_OPEN;
                  r_fail_cnt <= '0;
                  r_unlock   <= 1'b1;
                  r_timer    <= UNLOCK_TIME;
               end else begin
                  r_fail_cnt   <= w_fail_next;
                  r_fail_pulse <= 1'b1;
                  if (w_fail_next == MAX_FAIL) begin
                     r_state <= S_LOCKOUT;
                     r_alarm <= 1'b1;
                     r_timer <= LOCKOUT_TIME;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end

            S_OPEN: begin
               if (w_expired) begin
                  r_state     <= S_IDLE;
                  r_unlock    <= 1'b0;
                  r_entry     <= '0;
                  r_digit_cnt <= '0;
               end else if (w_key_evt) begin
                  if (w_is_digit) begin
                     // digits re-arm the unlock window so a new code can be keyed in
                     r_timer <= UNLOCK_TIME;
                     if (!w_full) begin
                        r_entry     <= w_shift;
                        r_digit_cnt <= r_digit_cnt + 3'd1;
                     end
                  end else if (w_is_enter) begin
                     r_entry     <= '0;
                     r_digit_cnt <= '0;
                     if (w_full) begin
                        r_code        <= r_entry;
                        r_saved_pulse <= 1'b1;
                        r_state       <= S_IDLE;
                        r_unlock      <= 1'b0;
                     end
                  end else if (w_is_clear) begin
                     r_state     <= S_IDLE;
                     r_unlock    <= 1'b0;
                     r_entry     <= '0;
                     r_digit_cnt <= '0;
                  end
               end
            end

            S_LOCKOUT: begin
               if (w_expired) begin
                  r_state    <= S_IDLE;
                  r_fail_cnt <= '0;
                  r_alarm    <= 1'b0;
               end
            end

            default: begin
               r_state     <= S_IDLE;
               r_unlock    <= 1'b0;
               r_alarm     <= 1'b0;
               r_entry     <= '0;
               r_digit_cnt <= '0;
            end
         endcase
      end
   end

   assign unlock      = r_unlock;
   assign alarm       = r_alarm;
   assign fail_pulse  = r_fail_pulse;
   assign saved_pulse = r_saved_pulse;
   assign entry       = r_entry;
   assign digit_cnt   = r_digit_cnt;

endmodule

// File: tb/tb_keypad_code_lock.sv
// Directed bench for keypad_code_lock with short timer parameters.
module tb_keypad_code_lock;

   logic        fin = 1'b0;
   logic        rst;
   logic [3:0]  keycode;
   logic        key_pulse;
   logic        unlock;
   logic        alarm;
   logic        fail_pulse;
   logic        saved_pulse;
   logic [15:0] entry;
   logic [2:0]  digit_cnt;

   int errors = 0;
   int checks = 0;
   int n_fail = 0;
   int n_saved = 0;
   int n_unlock_hi = 0;
   int n_alarm_hi = 0;

   always #5 fin = ~fin;

   keypad_code_lock #(
      .CODE_INIT    (16'h1234),
      .TIMEOUT      (24'd50),
      .UNLOCK_TIME  (24'd20),
      .LOCKOUT_TIME (24'd30),
      .MAX_FAIL     (2'd3)
   ) dut (
      .fin         (fin),
      .rst         (rst),
      .keycode     (keycode),
      .key_pulse   (key_pulse),
      .unlock      (unlock),
      .alarm       (alarm),
      .fail_pulse  (fail_pulse),
      .saved_pulse (saved_pulse),
      .entry       (entry),
      .digit_cnt   (digit_cnt)
   );

   always @(negedge fin) begin
      if (fail_pulse)  n_fail      <= n_fail + 1;
      if (saved_pulse) n_saved     <= n_saved + 1;
      if (unlock)      n_unlock_hi <= n_unlock_hi + 1;
      if (alarm)       n_alarm_hi  <= n_alarm_hi + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // called at a negedge; strobe high 3 cycles, low 2, ends on a negedge
   task automatic press(input logic [3:0] k);
      keycode   = k;
      key_pulse = 1'b1;
      repeat (3) @(negedge fin);
      key_pulse = 1'b0;
      repeat (2) @(negedge fin);
   endtask

   task automatic enter_code(input logic [15:0] c);
      for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
   endtask

   task automatic wait_low_unlock();
      for (int i = 0; i < 80 && unlock; i++) @(negedge fin);
   endtask

   task automatic wait_low_alarm();
      for (int i = 0; i < 80 && alarm; i++) @(negedge fin);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int snap_u, snap_a, snap_f, snap_s;
      rst       = 1'b1;
      key_pulse = 1'b0;
      keycode   = 4'd0;
      repeat (3) @(negedge fin);
      check("rst_unlock", 32'(unlock), 32'd0);
      check("rst_alarm", 32'(alarm), 32'd0);
      check("rst_fail", 32'(fail_pulse), 32'd0);
      check("rst_saved", 32'(saved_pulse), 32'd0);
      check("rst_entry", 32'(entry), 32'd0);
      check("rst_cnt", 32'(digit_cnt), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge fin);

      // correct code, then full unlock window
      press(4'd1);
      check("first_digit", 32'(entry), 32'h0001);
      check("first_cnt", 32'(digit_cnt), 32'd1);
      press(4'd2); press(4'd3); press(4'd4);
      check("c1_entry", 32'(entry), 32'h1234);
      check("c1_cnt", 32'(digit_cnt), 32'd4);
      check("c1_locked", 32'(unlock), 32'd0);
      snap_u = n_unlock_hi;
      snap_f = n_fail;
      press(4'd11);
      check("c1_unlock", 32'(unlock), 32'd1);
      check("c1_open_entry", 32'(entry), 32'd0);
      wait_low_unlock();
      check("c1_unlock_fell", 32'(unlock), 32'd0);
      check("c1_unlock_len", 32'(n_unlock_hi - snap_u), 32'd21);
      check("c1_idle_entry", 32'(entry), 32'd0);
      check("c1_no_fail", 32'(n_fail - snap_f), 32'd0);

      // short entry fails, over-length entry opens
      snap_f = n_fail;
      press(4'd1); press(4'd2); press(4'd11);
      check("short_fail", 32'(n_fail - snap_f), 32'd1);
      check("short_locked", 32'(unlock), 32'd0);
      check("short_entry", 32'(entry), 32'd0);
      enter_code(16'h1234);
      press(4'd5);
      check("long_entry", 32'(entry), 32'h1234);
      check("long_cnt", 32'(digit_cnt), 32'd4);
      press(4'd11);
      check("long_unlock", 32'(unlock), 32'd1);
      press(4'd10);
      check("star_relock", 32'(unlock), 32'd0);

      // three wrong entries trigger lockout
      snap_f = n_fail;
      enter_code(16'h9999); press(4'd11);
      enter_code(16'h9999); press(4'd11);
      check("lo_two_fails", 32'(n_fail - snap_f), 32'd2);
      check("lo_no_alarm_yet", 32'(alarm), 32'd0);
      enter_code(16'h9999);
      snap_a = n_alarm_hi;
      press(4'd11);
      check("lo_three_fails", 32'(n_fail - snap_f), 32'd3);
      check("lo_alarm", 32'(alarm), 32'd1);
      press(4'd5); press(4'd6);
      check("lo_keys_entry", 32'(entry), 32'd0);
      check("lo_keys_cnt", 32'(digit_cnt), 32'd0);
      wait_low_alarm();
      check("lo_alarm_fell", 32'(alarm), 32'd0);
      check("lo_alarm_len", 32'(n_alarm_hi - snap_a), 32'd31);
      enter_code(16'h1234); press(4'd11);
      check("lo_then_open", 32'(unlock), 32'd1);

      // change code while open
      snap_s = n_saved;
      enter_code(16'h5678);
      check("cc_entry", 32'(entry), 32'h5678);
      check("cc_still_open", 32'(unlock), 32'd1);
      press(4'd11);
      check("cc_saved", 32'(n_saved - snap_s), 32'd1);
      check("cc_relocked", 32'(unlock), 32'd0);
      snap_f = n_fail;
      enter_code(16'h1234); press(4'd11);
      check("cc_old_fails", 32'(n_fail - snap_f), 32'd1);
      check("cc_old_locked", 32'(unlock), 32'd0);
      enter_code(16'h5678); press(4'd11);
      check("cc_new_opens", 32'(unlock), 32'd1);
      press(4'd10);

      // inactivity timeout and clear
      snap_f = n_fail;
      press(4'd7);
      check("to_entry", 32'(entry), 32'h0007);
      repeat (48) @(negedge fin);
      check("to_before", 32'(entry), 32'h0007);
      @(negedge fin);
      check("to_after", 32'(entry), 32'd0);
      check("to_cnt", 32'(digit_cnt), 32'd0);
      check("to_no_fail", 32'(n_fail - snap_f), 32'd0);
      press(4'd1); press(4'd2);
      check("clr_pre", 32'(entry), 32'h0012);
      press(4'd10);
      check("clr_entry", 32'(entry), 32'd0);
      check("clr_cnt", 32'(digit_cnt), 32'd0);

      // long strobe yields one digit
      keycode   = 4'd3;
      key_pulse = 1'b1;
      repeat (20) @(negedge fin);
      check("hold_entry", 32'(entry), 32'h0003);
      check("hold_cnt", 32'(digit_cnt), 32'd1);
      repeat (25) @(negedge fin);
      check("hold_cnt_late", 32'(digit_cnt), 32'd1);
      repeat (55) @(negedge fin);
      key_pulse = 1'b0;
      repeat (2) @(negedge fin);
      check("hold_timed_out", 32'(digit_cnt), 32'd0);

      // async reset mid-entry restores CODE_INIT
      press(4'd1); press(4'd2);
      check("ar_pre", 32'(entry), 32'h0012);
      #2 rst = 1'b1;
      #1;
      check("ar_entry", 32'(entry), 32'd0);
      check("ar_cnt", 32'(digit_cnt), 32'd0);
      check("ar_unlock", 32'(unlock), 32'd0);
      check("ar_alarm", 32'(alarm), 32'd0);
      @(negedge fin);
      rst = 1'b0;
      repeat (2) @(negedge fin);
      enter_code(16'h1234); press(4'd11);
      check("ar_code_reverted", 32'(unlock), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/keypad_code_lock.md
# keypad_code_lock

Code-lock controller downstream of the keypad scanner. It takes the scanner's 4-bit `keycode` and key-press strobe, synchronises the strobe into the `fin` domain, and collects a four-digit BCD entry. It checks the entry against a stored code and drives unlock and alarm outputs. It also counts failed attempts, enforces a lockout, and lets the user change the code while unlocked.

## Interface
- `CODE_INIT`, default 16'h1234: reset value of the stored code (four BCD digits, MSD first).
- `TIMEOUT`, default 24'd4_000_000: idle cycles in ENTRY before auto-clear.
- `UNLOCK_TIME`, default 24'd8_000_000: cycles `unlock` stays high.
- `LOCKOUT_TIME`, default 24'd16_000_000: cycles of lockout.
- `MAX_FAIL`, default 2'd3: consecutive failures that trigger lockout (1..3).

- `fin`, in, 1: system clock; all state on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `keycode`, in, 4: scanner code. 0–9 are digits, 10 is clear (`*`), 11 is enter (`#`), 12–15 are ignored. It is stable while `key_pulse` is high.
- `key_pulse`, in, 1: press strobe from the scanner, asynchronous to `fin`. It is high for at least 3 `fin` cycles.
- `unlock`, out, 1: lock open.
- `alarm`, out, 1: lockout active.
- `fail_pulse`, out, 1: one-cycle strobe on each rejected attempt.
- `saved_pulse`, out, 1: one-cycle strobe when a new code is stored.
- `entry`, out, 16: digits entered so far, newest in `[3:0]`. Intended for the display.
- `digit_cnt`, out, 3: number of digits entered, 0..4.

## Operation
- **Front end:** `key_pulse` passes through a 2-FF synchroniser followed by a rising-edge detect, producing the one-cycle internal `key_evt`. `keycode` is sampled on `key_evt`.
- **Timer:** one shared 24-bit down-counter. It is reloaded on every state entry and on every accepted key in ENTRY. Expiry means the count is 0 while in a timed state.
- **IDLE:**
  - Digit key → ENTRY, with `entry = {12'h000, key}` and `digit_cnt = 1`.
  - `*`, `#` and codes 12–15 are ignored.
- **ENTRY:**
  - Digit key with `digit_cnt < 4`: `entry <= {entry[11:0], key}` and `digit_cnt + 1`.
  - Digit key with `digit_cnt == 4`: ignored, but it still reloads the timer.
  - `*`: clear `entry` and `digit_cnt`, go to IDLE.
  - `#`: go to CHECK.
  - Timer expiry: clear and go to IDLE. This is not counted as a failure.
- **CHECK (one cycle):**
  - Pass condition: `digit_cnt == 4` and `entry == code_reg`. On pass: go to OPEN and clear `fail_cnt`.
  - Otherwise: `fail_cnt + 1` and pulse `fail_pulse`. Then go to LOCKOUT if the new `fail_cnt == MAX_FAIL`, else to IDLE.
  - `entry` and `digit_cnt` clear on leaving CHECK.
- **OPEN:**
  - `unlock = 1`.
  - Digit keys accumulate exactly as in ENTRY.
  - `#` with `digit_cnt == 4`: `code_reg <= entry`, pulse `saved_pulse`, go to IDLE.
  - `#` with `digit_cnt < 4`: clear the entry and stay in OPEN.
  - `*`: go to IDLE immediately (relock).
  - Timer expiry (`UNLOCK_TIME`): go to IDLE.
  - Entry clears on exit.
- **LOCKOUT:**
  - `alarm = 1`; all keys are ignored.
  - Expiry (`LOCKOUT_TIME`): clear `fail_cnt`, go to IDLE.
- **Reset:**
  - All outputs are 0 and the state is IDLE.
  - `code_reg = CODE_INIT`, `fail_cnt = 0`, synchroniser flops are 0.
  - Reset mid-operation aborts everything and restores `CODE_INIT`. A code saved before reset is lost.

## Timing
- **Key latency:** if `key_pulse` rises before `fin` edge 0, `key_evt` is high after edge 1. `entry` and `digit_cnt` update on edge 2, so they are visible 2–3 cycles after the asynchronous rise.
- **One event per press:** a `key_pulse` held high yields exactly one event. A new event requires `key_pulse` to be low for at least 2 cycles.
- **Check latency:** `#` event → CHECK on edge N.
  - Pass: `unlock` rises on edge N+1.
  - Fail: `fail_pulse` is high for the cycle after edge N+1, and `alarm` rises on edge N+1 if the lockout threshold is reached.
- **Timed states:** `unlock` stays high exactly `UNLOCK_TIME + 1` cycles when not interrupted. `alarm` stays high exactly `LOCKOUT_TIME + 1` cycles.
- **Simultaneous events:** a key event in the same cycle as timer expiry is dropped, and expiry wins.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs.
- **Width rule:** `TIMEOUT`, `UNLOCK_TIME` and `LOCKOUT_TIME` must be less than 2^24.

## Test plan
All scenarios use `TIMEOUT = 50`, `UNLOCK_TIME = 20`, `LOCKOUT_TIME = 30`, `MAX_FAIL = 3`.

- **Correct code:** keys 1,2,3,4,`#` after reset → `entry` ends at 16'h1234 with `digit_cnt` = 4, then `unlock` = 1 for 21 cycles, then IDLE with `entry` = 0.
- **Over-length and short entry:** keys 1,2,3,4,5,`#` → 5 is ignored and the lock opens. Keys 1,2,`#` → one `fail_pulse`, `unlock` stays 0.
- **Lockout:** three wrong entries (9,9,9,9,`#`) → three `fail_pulse`s, with `alarm` = 1 after the third. Digit keys during the lockout leave `entry` = 0. `alarm` falls after 31 cycles; then the correct code opens the lock.
- **Change code:** in OPEN, enter 5,6,7,8,`#` → `saved_pulse` and IDLE. Then 1,2,3,4,`#` fails and 5,6,7,8,`#` opens.
- **Inactivity timeout and clear:** key 7, then 51 idle cycles → IDLE with `entry` = 0 and no `fail_pulse`. Keys 1,2,`*` → `entry` = 0, `digit_cnt` = 0.
- **Strobe handling:** `key_pulse` held high for 100 cycles gives exactly one digit. Assert `rst` asynchronously mid-entry (after 1,2) → all outputs are 0 immediately and the code reverts to 16'h1234.
